// File: rtl/pc_return_stack_if.sv
// Interface bundling the return-stack control inputs and status outputs.
// The master side (IF-stage control) drives the operations. The slave side
// (the stack) returns the top entry and the status flags.
interface pc_return_stack_if #(
   parameter int WIDTH = 32,
   parameter int PTR_W = 4
);
   logic             stall;
   logic             clear;
   logic             push;
   logic [WIDTH-1:0] push_pc;
   logic             pop;
   logic [WIDTH-1:0] top_pc;
   logic             empty;
   logic             full;
   logic [PTR_W:0]   count;
   logic             overflow;
   logic             underflow;

   modport master (
      output stall, clear, push, push_pc, pop,
      input  top_pc, empty, full, count, overflow, underflow
   );

   modport slave (
      input  stall, clear, push, push_pc, pop,
      output top_pc, empty, full, count, overflow, underflow
   );
endinterface

// File: rtl/pc_return_stack.sv
// Return-address stack (LIFO) for the IF stage.
// CALL pushes a return PC and RET pops it. A push and a pop in the same cycle
// replace the top entry. Overflow and underflow are sticky until a clear or
// a reset. The storage array has no reset; count alone decides which entries
// are valid, so an unwritten entry never reaches top_pc.
module pc_return_stack #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   parameter int PTR_W = 4
) (
   input logic                clk,
   input logic                rst_n,
   pc_return_stack_if.slave   bus
);

   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [PTR_W:0]   count_reg, count_next;
   logic             ovf_reg, ovf_next;
   logic             unf_reg, unf_next;
   logic             wr_en;
   logic [PTR_W-1:0] wr_idx;
   logic [PTR_W-1:0] top_idx;
   logic             is_empty, is_full;

   assign is_empty = (count_reg == '0);
   assign is_full  = (count_reg == DEPTH_C);
   // Index of the top entry. When the stack is full the low bits are zero,
   // so the subtraction wraps to DEPTH-1, which is the correct slot.
   assign top_idx  = count_reg[PTR_W-1:0] - PTR_W'(1);

   // Decide the next count, the flags and the storage write for this edge.
   // Priority: stall, then clear, then push/pop.
   always_comb begin
      count_next = count_reg;
      ovf_next   = ovf_reg;
      unf_next   = unf_reg;
      wr_en      = 1'b0;
      wr_idx     = count_reg[PTR_W-1:0];
      if (bus.stall) begin
         // hold everything
      end else if (bus.clear) begin
         count_next = '0;
         ovf_next   = 1'b0;
         unf_next   = 1'b0;
      end else if (bus.push && bus.pop) begin
         wr_en = 1'b1;
         if (is_empty) begin
            // acts as a plain push into slot 0, but the pop is still an error
            wr_idx     = '0;
            count_next = (PTR_W+1)'(1);
            unf_next   = 1'b1;
         end else begin
            wr_idx = top_idx;
         end
      end else if (bus.push) begin
         if (is_full) begin
            ovf_next = 1'b1;
         end else begin
            wr_en      = 1'b1;
            count_next = count_reg + (PTR_W+1)'(1);
         end
      end else if (bus.pop) begin
         if (is_empty) begin
            unf_next = 1'b1;
         end else begin
            count_next = count_reg - (PTR_W+1)'(1);
         end
      end
   end

   // Control state: count and the sticky flags, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
         ovf_reg   <= 1'b0;
         unf_reg   <= 1'b0;
      end else begin
         count_reg <= count_next;
         ovf_reg   <= ovf_next;
         unf_reg   <= unf_next;
      end
   end

   // Storage write. There is no reset because the contents are don't-care.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= bus.push_pc;
      end
   end

   assign bus.top_pc    = is_empty ? '0 : mem[top_idx];
   assign bus.empty     = is_empty;
   assign bus.full      = is_full;
   assign bus.count     = count_reg;
   assign bus.overflow  = ovf_reg;
   assign bus.underflow = unf_reg;

endmodule

// File: tb/tb_pc_return_stack.sv
// Testbench for pc_return_stack. It first runs directed scenarios with
// literal expectations, then random traffic. A queue-based reference model
// is compared against the DUT on every falling edge.
module tb_pc_return_stack;

   localparam int WIDTH = 32;
   localparam int DEPTH = 16;
   localparam int PTR_W = 4;

   logic clk;
   logic rst_n;

   pc_return_stack_if #(.WIDTH(WIDTH), .PTR_W(PTR_W)) bus ();

   pc_return_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a queue whose last element is the top entry.
   logic [WIDTH-1:0] model_q[$];
   bit               model_ovf;
   bit               model_unf;
   bit               chk_en;

   int n_cmp;
   int n_err;

   task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [WIDTH-1:0] model_top();
      if (model_q.size() == 0) return '0;
      return model_q[model_q.size()-1];
   endfunction

   task automatic model_reset();
      model_q.delete();
      model_ovf = 1'b0;
      model_unf = 1'b0;
   endtask

   // Apply one edge's worth of behaviour to the model, from the stack rules.
   task automatic model_step(input bit s, input bit c, input bit pu, input logic [WIDTH-1:0] pc, input bit po);
      if (s) return;
      if (c) begin
         model_reset();
      end else if (pu && po) begin
         if (model_q.size() == 0) begin
            model_q.push_back(pc);
            model_unf = 1'b1;
         end else begin
            model_q[model_q.size()-1] = pc;
         end
      end else if (pu) begin
         if (model_q.size() == DEPTH) model_ovf = 1'b1;
         else model_q.push_back(pc);
      end else if (po) begin
         if (model_q.size() == 0) model_unf = 1'b1;
         else void'(model_q.pop_back());
      end
   endtask

   // Compare process: check every DUT output against the model on each falling edge.
   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         chk("count",     WIDTH'(bus.count),     WIDTH'(model_q.size()));
         chk("top_pc",    bus.top_pc,            model_top());
         chk("empty",     WIDTH'(bus.empty),     WIDTH'(model_q.size() == 0));
         chk("full",      WIDTH'(bus.full),      WIDTH'(model_q.size() == DEPTH));
         chk("overflow",  WIDTH'(bus.overflow),  WIDTH'(model_ovf));
         chk("underflow", WIDTH'(bus.underflow), WIDTH'(model_unf));
      end
   end

   // Runs one clock cycle. It is entered 1 time unit after a rising edge,
   // drives the inputs, steps the model at the edge and returns 1 unit after it.
   task automatic cyc(input bit s, input bit c, input bit pu, input logic [WIDTH-1:0] pc, input bit po);
      bus.stall   = s;
      bus.clear   = c;
      bus.push    = pu;
      bus.push_pc = pc;
      bus.pop     = po;
      @(posedge clk);
      model_step(s, c, pu, pc, po);
      #1;
      bus.stall = 1'b0;
      bus.clear = 1'b0;
      bus.push  = 1'b0;
      bus.pop   = 1'b0;
   endtask

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      chk_en  = 1'b0;
      model_reset();
      rst_n       = 1'b0;
      bus.stall   = 1'b0;
      bus.clear   = 1'b0;
      bus.push    = 1'b0;
      bus.push_pc = '0;
      bus.pop     = 1'b0;

      // 1. Reset with no clock edge yet.
      #2;
      chk("rst_count",     WIDTH'(bus.count),     0);
      chk("rst_empty",     WIDTH'(bus.empty),     1);
      chk("rst_full",      WIDTH'(bus.full),      0);
      chk("rst_top",       bus.top_pc,            0);
      chk("rst_overflow",  WIDTH'(bus.overflow),  0);
      chk("rst_underflow", WIDTH'(bus.underflow), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_en = 1'b1;

      // 2. Three pushes, then three pops.
      cyc(0, 0, 1, 32'h10, 0);
      cyc(0, 0, 1, 32'h20, 0);
      cyc(0, 0, 1, 32'h30, 0);
      chk("t2_count", WIDTH'(bus.count), 3);
      chk("t2_top",   bus.top_pc, 32'h30);
      cyc(0, 0, 0, 0, 1);
      chk("t2_pop1", bus.top_pc, 32'h20);
      cyc(0, 0, 0, 0, 1);
      chk("t2_pop2", bus.top_pc, 32'h10);
      cyc(0, 0, 0, 0, 1);
      chk("t2_pop3", bus.top_pc, 0);
      chk("t2_empty", WIDTH'(bus.empty), 1);

      // 3. Fill to DEPTH, then overflow.
      for (int i = 1; i <= DEPTH; i++) cyc(0, 0, 1, WIDTH'(i), 0);
      chk("t3_full", WIDTH'(bus.full), 1);
      chk("t3_top",  bus.top_pc, 16);
      cyc(0, 0, 1, 32'h99, 0);
      chk("t3_overflow", WIDTH'(bus.overflow), 1);
      chk("t3_count",    WIDTH'(bus.count), 16);
      chk("t3_top2",     bus.top_pc, 16);
      // push and pop together while full replaces the top and raises no new error
      cyc(0, 0, 1, 32'h77, 1);
      chk("t3_replace_full", bus.top_pc, 32'h77);

      // 4. Underflow, then clear.
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 1);
      chk("t4_underflow", WIDTH'(bus.underflow), 1);
      chk("t4_count",     WIDTH'(bus.count), 0);
      cyc(0, 1, 1, 32'h5, 1);
      chk("t4_cleared",   WIDTH'(bus.underflow), 0);
      chk("t4_clear_ign", WIDTH'(bus.count), 0);

      // 5. Push and pop together replace the top entry.
      cyc(0, 0, 1, 32'h10, 0);
      cyc(0, 0, 1, 32'h20, 0);
      cyc(0, 0, 1, 32'h55, 1);
      chk("t5_count", WIDTH'(bus.count), 2);
      chk("t5_top",   bus.top_pc, 32'h55);
      cyc(0, 0, 0, 0, 1);
      chk("t5_pop",   bus.top_pc, 32'h10);
      // push and pop together while empty: acts as a push and sets underflow
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 1, 32'hAB, 1);
      chk("t5_emp_count", WIDTH'(bus.count), 1);
      chk("t5_emp_top",   bus.top_pc, 32'hAB);
      chk("t5_emp_unf",   WIDTH'(bus.underflow), 1);

      // 6. Stall freezes state; an asynchronous reset empties the stack.
      cyc(0, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 1, WIDTH'(32'h100 + i), 0);
      cyc(1, 0, 1, 32'h40, 0);
      chk("t6_stall_count", WIDTH'(bus.count), 5);
      chk("t6_stall_top",   bus.top_pc, 32'h104);
      cyc(1, 0, 0, 0, 1);
      chk("t6_stall_pop",   WIDTH'(bus.underflow), 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_async_count", WIDTH'(bus.count), 0);
      chk("t6_async_empty", WIDTH'(bus.empty), 1);
      chk("t6_async_top",   bus.top_pc, 0);
      model_reset();
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Random traffic, first biased toward pushes and then toward pops.
      for (int i = 0; i < 3000; i++) begin
         bit s, c, pu, po;
         int bias;
         bias = (i < 1500) ? 60 : 40;
         s  = ($urandom_range(0, 7) == 0);
         c  = ($urandom_range(0, 99) == 0);
         pu = ($urandom_range(0, 99) < bias);
         po = ($urandom_range(0, 99) < (100 - bias));
         cyc(s, c, pu, WIDTH'($urandom()), po);
      end

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
